ram64_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer sharing one RAM64 (16-bit x 64 words, write on clk edge when

---
 rtl/ram64_arbiter_if.sv | 28 ++
 rtl/ram64_arbiter.sv | 99 +++++++++
 tb/tb_ram64_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram64_arbiter_if.sv
// rtl/ram64_arbiter_if.sv - requester-side bus of the two-port RAM64 arbiter
interface ram64_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/ram64_arbiter.sv
// rtl/ram64_arbiter.sv - round-robin two-requester sequencer in front of a RAM64
module ram64_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ram64_arbiter_if.slave bus,
  output logic          busy,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  input  logic [DW-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;

  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Ties go to whichever port did not win last time; a lone request always wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ~last_grant;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
    sel_we    = winner ? bus.we1    : bus.we0;
    sel_addr  = winner ? bus.addr1  : bus.addr0;
    sel_wdata = winner ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      busy        <= 1'b0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
      ram_address <= '0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            ram_address <= sel_addr;
            ram_load    <= sel_we;
            ram_in      <= sel_wdata;
            grant       <= winner;
            last_grant  <= winner;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // ram_out is still the pre-write contents here, so a write returns the old word.
          if (grant) begin
            bus.rdata1 <= ram_out;
            bus.ack1   <= 1'b1;
          end else begin
            bus.rdata0 <= ram_out;
            bus.ack0   <= 1'b1;
          end
          ram_load <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          ram_load <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram64_arbiter.sv
// tb/tb_ram64_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_ram64_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_out;

  ram64_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram64_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .ram_in(ram_in),
    .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM64 stand-in
  logic [DW-1:0] ram [64];
  assign ram_out = ram[ram_address];
  always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

  // Requester-side stimulus
  logic          r   [2];
  logic          rw  [2];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rd  [2];

  // Reference: memory image plus timing of the single outstanding access
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] e_rd [2];
  int            n, g, free_edge, last, w;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic apply();
    bus.req0 = r[0]; bus.we0 = rw[0]; bus.addr0 = ra[0]; bus.wdata0 = rd[0];
    bus.req1 = r[1]; bus.we1 = rw[1]; bus.addr1 = ra[1]; bus.wdata1 = rd[1];
  endtask

  task automatic model_reset();
    g = -10; free_edge = 0; last = 1; w = 0;
    c_we = 1'b0; c_addr = '0; c_data = '0;
    e_rd[0] = '0; e_rd[1] = '0;
  endtask

  function automatic logic done(input int p);
    return (n == g + 1) && (w == p);
  endfunction

  // One clock: advance the model on the edge, then compare everything mid-cycle.
  task automatic step();
    @(posedge clk);
    n++;
    if (rst_n) begin
      if (n == g + 1) begin
        e_rd[w] = ref_mem[c_addr];
        if (c_we) ref_mem[c_addr] = c_data;
      end
      if (n >= free_edge && (r[0] || r[1])) begin
        if (r[0] && r[1]) w = 1 - last;
        else w = r[1] ? 1 : 0;
        c_we = rw[w]; c_addr = ra[w]; c_data = rd[w];
        g = n; free_edge = n + 3; last = w;
      end
    end
    @(negedge clk);
    chk("busy",        32'(busy),        32'(n == g || n == g + 1));
    chk("ack0",        32'(bus.ack0),    32'(n == g + 1 && w == 0));
    chk("ack1",        32'(bus.ack1),    32'(n == g + 1 && w == 1));
    chk("ram_load",    32'(ram_load),    32'(n == g && c_we));
    chk("ram_address", 32'(ram_address), 32'(c_addr));
    chk("ram_in",      32'(ram_in),      32'(c_data));
    chk("rdata0",      32'(bus.rdata0),  32'(e_rd[0]));
    chk("rdata1",      32'(bus.rdata1),  32'(e_rd[1]));
  endtask

  task automatic do_access(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] got);
    int loads;
    bit ok;
    loads = 0; ok = 0;
    r[p] = 1'b1; rw[p] = we; ra[p] = a; rd[p] = d;
    apply();
    for (int k = 0; k < 12 && !ok; k++) begin
      step();
      if (ram_load) loads++;
      if (done(p)) ok = 1;
    end
    if (!ok) chk("access_timeout", 32'd0, 32'd1);
    chk("load_cycles", 32'(loads), 32'(we));
    got = (p == 1) ? bus.rdata1 : bus.rdata0;
    r[p] = 1'b0;
    apply();
  endtask

  task automatic rand_fields(input int p);
    rw[p] = 1'($urandom_range(1, 0));
    ra[p] = AW'($urandom_range(63, 0));
    rd[p] = DW'($urandom);
  endtask

  initial begin
    logic [DW-1:0] got;
    int exp_port, acks, idles;
    n = 0;
    for (int i = 0; i < 64; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin r[p] = 1'b0; rw[p] = 1'b0; ra[p] = '0; rd[p] = '0; end
    model_reset();

    // Reset state, with both requests already held for the tie test
    r[0] = 1'b1; r[1] = 1'b1;
    apply();
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ack0",  32'(bus.ack0), 32'd0);
    chk("rst_ack1",  32'(bus.ack1), 32'd0);
    chk("rst_load",  32'(ram_load), 32'd0);
    chk("rst_addr",  32'(ram_address), 32'd0);
    chk("rst_in",    32'(ram_in), 32'd0);
    chk("rst_rd0",   32'(bus.rdata0), 32'd0);
    chk("rst_rd1",   32'(bus.rdata1), 32'd0);
    rst_n = 1'b1;

    // Both held: grants 0,1,0,1..., never two acks together
    exp_port = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("tie_both_ack", 32'(bus.ack0 && bus.ack1), 32'd0);
      if (bus.ack0 || bus.ack1) begin
        chk("tie_order", 32'(bus.ack1), 32'(exp_port));
        exp_port = 1 - exp_port;
      end
    end
    r[0] = 1'b0; r[1] = 1'b0; apply();
    repeat (3) step();

    // Only req1 held: ack every third cycle, busy low one cycle between
    r[1] = 1'b1; rw[1] = 1'b0; ra[1] = 6'd5; apply();
    acks = 0; idles = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (bus.ack1) acks++;
      if (!busy) idles++;
    end
    chk("solo_acks", 32'(acks), 32'd3);
    chk("solo_idle", 32'(idles), 32'd3);
    r[1] = 1'b0; apply();
    repeat (3) step();

    do_access(0, 1'b1, 6'd8, 16'h2008, got);
    do_access(0, 1'b0, 6'd8, 16'h0000, got);
    chk("rd_after_wr", 32'(got), 32'h2008);

    do_access(0, 1'b1, 6'd63, 16'h7063, got);
    do_access(1, 1'b1, 6'd63, 16'hBEEF, got);
    chk("wr_old_val", 32'(got), 32'h7063);
    do_access(0, 1'b0, 6'd63, 16'h0000, got);
    chk("top_addr", 32'(got), 32'hBEEF);

    // Reset during a write's ACCESS cycle must suppress the write and the ack
    do_access(0, 1'b1, 6'd10, 16'h300a, got);
    step();
    r[0] = 1'b1; rw[0] = 1'b1; ra[0] = 6'd10; rd[0] = 16'h1234; apply();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_load", 32'(ram_load), 32'd0);
    chk("rst_mid_ack",  32'(bus.ack0), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    r[0] = 1'b0; apply();
    @(posedge clk); n++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_access(0, 1'b0, 6'd10, 16'h0000, got);
    chk("no_write_on_rst", 32'(got), 32'h300a);

    // Late req1 while port0 is in flight: port0 first, rdata0 held afterwards
    step();
    r[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'd63; apply();
    step();
    r[1] = 1'b1; rw[1] = 1'b0; ra[1] = 6'd10; apply();
    exp_port = 0;
    for (int k = 0; k < 12 && (r[0] || r[1]); k++) begin
      step();
      if (bus.ack0 || bus.ack1) begin
        chk("late_order", 32'(bus.ack1), 32'(exp_port));
        if (bus.ack1) begin
          chk("late_rd1", 32'(bus.rdata1), 32'h300a);
          chk("late_rd0_held", 32'(bus.rdata0), 32'hBEEF);
        end
        r[exp_port] = 1'b0; apply();
        exp_port = 1;
      end
    end
    chk("late_done", 32'(r[0] || r[1]), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (r[p] && done(p)) begin
          if ($urandom_range(1, 0) == 0) rand_fields(p);
          else r[p] = 1'b0;
        end else if (r[p] && !(w == p && n == g)) begin
          if ($urandom_range(3, 0) == 0) rand_fields(p);
        end else if (!r[p] && $urandom_range(2, 0) == 0) begin
          r[p] = 1'b1;
          rand_fields(p);
        end
      end
      apply();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
